// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: arctangent table, sequencer state encoding and the gain constant.
package cordic_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Reciprocal CORDIC gain in Q3.29; callers pre-scale x/y by this.
    localparam logic signed [31:0] CORDIC_K = 32'sd326016437;

    // atan(2^-i) in Q3.29 radians, i = 0..23.
    function automatic logic [31:0] atan_q(input logic [4:0] i);
        case (i)
            5'd0:    return 32'd421657428;
            5'd1:    return 32'd248918915;
            5'd2:    return 32'd131521918;
            5'd3:    return 32'd66762579;
            5'd4:    return 32'd33510843;
            5'd5:    return 32'd16771758;
            5'd6:    return 32'd8387925;
            5'd7:    return 32'd4194219;
            5'd8:    return 32'd2097141;
            5'd9:    return 32'd1048575;
            5'd10:   return 32'd524288;
            5'd11:   return 32'd262144;
            5'd12:   return 32'd131072;
            5'd13:   return 32'd65536;
            5'd14:   return 32'd32768;
            5'd15:   return 32'd16384;
            5'd16:   return 32'd8192;
            5'd17:   return 32'd4096;
            5'd18:   return 32'd2048;
            5'd19:   return 32'd1024;
            5'd20:   return 32'd512;
            5'd21:   return 32'd256;
            5'd22:   return 32'd128;
            5'd23:   return 32'd64;
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One combinational CORDIC micro-rotation in rotation mode; the caller supplies shift i
// and the matching arctangent.
module cordic_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] y,
    input  logic signed [WIDTH-1:0] z,
    input  logic signed [WIDTH-1:0] angle,
    input  logic        [4:0]       shift,
    output logic signed [WIDTH-1:0] x_next,
    output logic signed [WIDTH-1:0] y_next,
    output logic signed [WIDTH-1:0] z_next
);

    logic signed [WIDTH-1:0] x_sh;
    logic signed [WIDTH-1:0] y_sh;
    logic                    rotate_pos;

    always_comb begin
        x_sh       = x >>> shift;
        y_sh       = y >>> shift;
        // z == 0 rotates the negative way, so only strictly positive z takes this branch
        rotate_pos = !z[WIDTH-1] && (z != '0);
        if (rotate_pos) begin
            x_next = x - y_sh;
            y_next = y + x_sh;
            z_next = z - angle;
        end else begin
            x_next = x + y_sh;
            y_next = y - x_sh;
            z_next = z + angle;
        end
    end

endmodule

// File: rtl/cordic_sequencer.sv
// Iterative CORDIC rotator: one micro-rotation per clock, valid/ready handshakes on both
// sides, result held in output registers until the consumer takes it.
module cordic_sequencer
    import cordic_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] z_out,
    output logic                    busy,
    output logic        [4:0]       iter_cnt
);

    localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

    state_e                  state;
    logic signed [WIDTH-1:0] x_w;
    logic signed [WIDTH-1:0] y_w;
    logic signed [WIDTH-1:0] z_w;
    logic signed [WIDTH-1:0] x_nx;
    logic signed [WIDTH-1:0] y_nx;
    logic signed [WIDTH-1:0] z_nx;
    logic signed [WIDTH-1:0] angle;
    logic                    accept;

    // DONE with out_ready lets a new operand in on the same edge the result retires
    assign in_ready = (state == StIdle) || ((state == StDone) && out_ready);
    assign accept   = in_valid && in_ready;
    assign angle    = WIDTH'(atan_q(iter_cnt));

    cordic_stage #(
        .WIDTH(WIDTH)
    ) u_stage (
        .x      (x_w),
        .y      (y_w),
        .z      (z_w),
        .angle  (angle),
        .shift  (iter_cnt),
        .x_next (x_nx),
        .y_next (y_nx),
        .z_next (z_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            x_w       <= '0;
            y_w       <= '0;
            z_w       <= '0;
            x_out     <= '0;
            y_out     <= '0;
            z_out     <= '0;
            iter_cnt  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (accept) begin
                        x_w      <= x_in;
                        y_w      <= y_in;
                        z_w      <= z_in;
                        iter_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= StRun;
                    end
                end
                StRun: begin
                    x_w <= x_nx;
                    y_w <= y_nx;
                    z_w <= z_nx;
                    if (iter_cnt == LAST_ITER) begin
                        x_out     <= x_nx;
                        y_out     <= y_nx;
                        z_out     <= z_nx;
                        out_valid <= 1'b1;
                        state     <= StDone;
                    end else begin
                        iter_cnt <= iter_cnt + 5'd1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            x_w      <= x_in;
                            y_w      <= y_in;
                            z_w      <= z_in;
                            iter_cnt <= '0;
                            state    <= StRun;
                        end else begin
                            busy  <= 1'b0;
                            state <= StIdle;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_sequencer.sv
// Self-checking bench for cordic_sequencer: vector table plus hand-written handshake,
// back-pressure, back-to-back and reset sequences, results checked through a scoreboard.
module tb_cordic_sequencer;
    import cordic_pkg::*;

    localparam int ITER  = 16;
    localparam int WIDTH = 32;
    localparam real ONE  = 536870912.0;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    out_ready = 1'b1;
    logic signed [WIDTH-1:0] x_in = '0;
    logic signed [WIDTH-1:0] y_in = '0;
    logic signed [WIDTH-1:0] z_in = '0;
    logic                    in_ready;
    logic                    out_valid;
    logic signed [WIDTH-1:0] x_out;
    logic signed [WIDTH-1:0] y_out;
    logic signed [WIDTH-1:0] z_out;
    logic                    busy;
    logic [4:0]              iter_cnt;

    cordic_sequencer #(
        .WIDTH(WIDTH),
        .ITER (ITER)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out),
        .busy      (busy),
        .iter_cnt  (iter_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [31:0] xi;
        logic signed [31:0] yi;
        logic signed [31:0] zi;
        logic signed [31:0] xe;
        logic signed [31:0] ye;
        logic signed [31:0] ze;
        bit                 phys;
    } exp_t;

    typedef struct {
        logic signed [31:0] x;
        logic signed [31:0] y;
        logic signed [31:0] z;
        bit                 phys;
    } vec_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic ov_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_tol(input string name, input longint act, input longint req,
                             input longint tol);
        longint diff;
        diff = act - req;
        if (diff < 0) diff = -diff;
        n_tests++;
        if (diff > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, req, tol);
        end
    endtask

    // Straight rotation-mode CORDIC with wrapping 32-bit arithmetic.
    function automatic exp_t model(input logic signed [31:0] xi, input logic signed [31:0] yi,
                                   input logic signed [31:0] zi, input bit phys);
        exp_t               e;
        logic signed [31:0] x, y, z, xt, a;
        x = xi;
        y = yi;
        z = zi;
        for (int i = 0; i < ITER; i++) begin
            xt = x;
            a  = atan_q(5'(i));
            if (z > 0) begin
                x = x - (y >>> i);
                y = y + (xt >>> i);
                z = z - a;
            end else begin
                x = x + (y >>> i);
                y = y - (xt >>> i);
                z = z + a;
            end
        end
        e.xi = xi; e.yi = yi; e.zi = zi;
        e.xe = x;  e.ye = y;  e.ze = z;
        e.phys = phys;
        return e;
    endfunction

    // For x_in = K, y_in = 0 the result is a unit vector at the angle actually rotated,
    // z_in - z_out; the residual z_out is bounded by the last table entry.
    task automatic check_result();
        exp_t e;
        real  ang;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out_valid: got out_valid=1, expected no pending result");
        end else begin
            e = sb.pop_front();
            check("x_out", x_out, e.xe);
            check("y_out", y_out, e.ye);
            check("z_out", z_out, e.ze);
            if (e.phys) begin
                ang = (real'(e.zi) - real'(z_out)) / ONE;
                check_tol("x_unit", x_out, longint'(ONE * $cos(ang)), 48);
                check_tol("y_unit", y_out, longint'(ONE * $sin(ang)), 48);
                check_tol("z_residual", z_out, 0, longint'(atan_q(5'(ITER - 1))));
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            ov_prev <= 1'b0;
        end else begin
            if (out_valid && !ov_prev) check_result();
            ov_prev <= out_valid;
        end
    end

    // Present an operand, push its expectation, return cycle stamp of the accepting edge.
    task automatic send(input logic signed [31:0] x, input logic signed [31:0] y,
                        input logic signed [31:0] z, input bit phys, output int acc);
        @(negedge clk);
        x_in = x;
        y_in = y;
        z_in = z;
        in_valid = 1'b1;
        for (int k = 0; k < 100 && !in_ready; k++) @(negedge clk);
        acc = cyc;
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0, expected 1 within 100 cycles");
            in_valid = 1'b0;
        end else begin
            sb.push_back(model(x, y, z, phys));
            @(negedge clk);
            acc = cyc;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_out(output int t);
        t = -1;
        for (int k = 0; k < 100; k++) begin
            if (out_valid) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        if (t < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL result_timeout: got out_valid=0, expected 1 within 100 cycles");
            t = cyc;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t               vecs[8];
        int                 acc, t, t1, t2, seen, cnt;
        logic signed [31:0] xs, ys, zs;

        vecs[0] = '{CORDIC_K, 32'sd0, 32'sd0, 1'b1};
        vecs[1] = '{CORDIC_K, 32'sd0, 32'sd421657428, 1'b1};
        vecs[2] = '{CORDIC_K, 32'sd0, -32'sd421657428, 1'b1};
        vecs[3] = '{CORDIC_K, 32'sd0, 32'sd843314856, 1'b1};
        vecs[4] = '{CORDIC_K, 32'sd0, -32'sd843314856, 1'b1};
        vecs[5] = '{32'sd100000000, -32'sd200000000, 32'sd300000000, 1'b0};
        vecs[6] = '{-32'sd500000000, 32'sd400000000, -32'sd100000000, 1'b0};
        vecs[7] = '{32'sh7fff0000, 32'sh7fff0000, 32'sd0, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_iter_cnt", iter_cnt, 0);
        check("rst_x_out", x_out, 0);
        check("rst_z_out", z_out, 0);
        rst_n = 1'b1;

        // Vector table, consumer always ready
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            send(vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].phys, acc);
            check("busy_run", busy, 1);
            wait_out(t);
            check("latency", t - acc, ITER);
            @(negedge clk);
            check("idle_after_retire", busy, 0);
        end

        // Back-pressure: result held for 5 cycles, then retired to IDLE
        out_ready = 1'b0;
        send(CORDIC_K, 32'sd0, 32'sd421657428, 1'b1, acc);
        wait_out(t);
        check("bp_latency", t - acc, ITER);
        xs = x_out;
        ys = y_out;
        zs = z_out;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_x_hold", x_out, xs);
            check("bp_y_hold", y_out, ys);
            check("bp_z_hold", z_out, zs);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", in_ready, 1);
        @(negedge clk);
        check("bp_idle_out_valid", out_valid, 0);
        check("bp_idle_busy", busy, 0);

        // Back-to-back: in_valid held high across RUN, second operand taken on DONE edge
        @(negedge clk);
        x_in = 32'sd200000000; y_in = 32'sd150000000; z_in = 32'sd500000000;
        in_valid = 1'b1;
        sb.push_back(model(x_in, y_in, z_in, 1'b0));
        @(negedge clk);
        x_in = -32'sd250000000; y_in = 32'sd50000000; z_in = -32'sd600000000;
        t1 = -1;
        t2 = -1;
        seen = 0;
        for (int k = 0; k < 60 && seen < 2; k++) begin
            if (out_valid && seen == 0) begin
                t1 = cyc;
                seen = 1;
                check("b2b_in_ready", in_ready, 1);
                sb.push_back(model(x_in, y_in, z_in, 1'b0));
                @(negedge clk);
                in_valid = 1'b0;
            end else if (out_valid && seen == 1) begin
                t2 = cyc;
                seen = 2;
            end else begin
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        check("b2b_results_seen", seen, 2);
        check("b2b_spacing", t2 - t1, ITER + 1);
        @(negedge clk);

        // Reset in the middle of RUN
        send(CORDIC_K, 32'sd0, 32'sd200000000, 1'b1, acc);
        for (int k = 0; k < 40 && iter_cnt != 5'd7; k++) @(negedge clk);
        check("pre_reset_iter", iter_cnt, 7);
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_busy", busy, 0);
        check("ar_iter_cnt", iter_cnt, 0);
        check("ar_x_out", x_out, 0);
        check("ar_y_out", y_out, 0);
        check("ar_z_out", z_out, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", in_ready, 1);
        cnt = 0;
        for (int k = 0; k < 25; k++) begin
            if (out_valid) cnt++;
            @(negedge clk);
        end
        check("aborted_not_reported", cnt, 0);
        send(CORDIC_K, 32'sd0, -32'sd300000000, 1'b1, acc);
        wait_out(t);
        check("post_reset_latency", t - acc, ITER);
        @(negedge clk);

        // in_valid toggling with junk operands during RUN
        send(32'sd123456789, -32'sd98765432, -32'sd300000000, 1'b0, acc);
        check("tog_iter0", iter_cnt, 0);
        for (int k = 1; k <= ITER - 2; k++) begin
            in_valid = ~in_valid;
            x_in = $urandom();
            y_in = $urandom();
            z_in = $urandom();
            @(negedge clk);
            check("tog_iter", iter_cnt, k);
        end
        in_valid = 1'b0;
        wait_out(t);
        check("tog_latency", t - acc, ITER);
        repeat (3) @(negedge clk);

        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
